dpram_mask: RTL and testbench
=============================

# dpram_mask

Parametrised simple dual-port RAM: independent write and read ports on one clock, per-lane write masking, a selectable read pipeline depth, and a hardware clear sequencer that fills every word with a constant after reset or on request. It is the next-generation replacement for the plain one-cycle dual-port memory in the memory subsystem. It is intended for coefficient and scratch storage that must start from a known state without a software init loop.

## Interface
- ADDR_W, 6, address width; depth = 2**ADDR_W words
- DATA_W, 10, word width; must be an exact multiple of LANES
- LANES, 2, number of write-mask lanes; lane width LW = DATA_W/LANES, lane i = bits [i*LW +: LW]
- RD_LAT, 1, read latency in cycles; legal values 1 or 2
- FILL, 0, DATA_W-bit value written to every word by the clear sequence
- clk  in  1  single clock; all state changes on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- write  in  1  write request
- wmask  in  LANES  lane enables for write; bit i enables lane i
- addr_w  in  ADDR_W  write address
- datain  in  DATA_W  write data
- read  in  1  read request
- addr_r  in  ADDR_W  read address
- clear  in  1  start a clear sweep (sampled only when idle)
- dataout  out  DATA_W  read data
- dout_valid  out  1  one-cycle strobe marking new dataout
- busy  out  1  clear sweep in progress; user ports ignored

## Operation
- FSM states: CLEAR, IDLE. Reset forces CLEAR with sweep pointer ptr = 0.
- CLEAR: each cycle, mem[ptr] <= FILL (all lanes) and ptr increments. On the cycle ptr == 2**ADDR_W-1, write the last word and go to IDLE. busy = 1 throughout CLEAR.
- IDLE: clear = 1 goes to CLEAR next cycle with ptr = 0. During CLEAR, clear is ignored; an in-progress sweep does not restart.
- While busy, write, read and clear requests are dropped, not queued. No dout_valid is produced for dropped reads.
- Write (IDLE, write = 1): for each i with wmask[i] = 1, lane i of mem[addr_w] <= lane i of datain. Unmasked lanes keep their value. wmask = 0 is a legal no-op.
- Read (IDLE, read = 1): mem[addr_r] is fetched. It appears on dataout RD_LAT cycles later, together with a one-cycle dout_valid. Reads may be issued every cycle; the pipeline is fully pipelined, with no stalls.
- dataout holds its last value when no read completes.
- Same-cycle read and write to the same address: see Configuration.
- Memory array is not reset; its contents are defined only by the clear sweep.
- Reset values: dataout = 0, dout_valid = 0, busy = 1, state = CLEAR, ptr = 0, RD_LAT pipeline valid bits = 0.

## Timing
- Clear sweep: the first rising edge after rst_n deasserts writes address 0. Edge k writes address k-1. busy falls after edge 2**ADDR_W, so busy is high for 2**ADDR_W edges (64 with defaults).
- A read sampled on the first IDLE edge returns FILL.
- clear sampled at edge n (IDLE): busy = 1 after edge n. The sweep writes address 0 at edge n+1. busy falls after edge n + 2**ADDR_W.
- A read accepted at edge n: dataout and dout_valid are updated after edge n+RD_LAT.
- Write at edge n is visible to a different-address or later read accepted at edge n+1 or later.
- rst_n asserted mid-sweep or mid-read: outputs go to their reset values immediately. In-flight reads are discarded. The sweep restarts from address 0 on release.
- clear asserted in the same cycle as read or write in IDLE: that read and write are still performed. The sweep begins the next cycle and overwrites the memory.

## Configuration
- DPRAM_BYPASS_EN defined: on a same-cycle read and write to the same address, the returned word takes written lanes from datain and unmasked lanes from the old memory contents (write-first, lane-merged).
- DPRAM_BYPASS_EN undefined: the same collision returns the old memory contents for all lanes (read-first). No forwarding logic is built.
- Latency and dout_valid timing are identical in both builds.

## Test plan
- Reset release, defaults, FILL = 10'h155: busy high for exactly 64 edges. Then reads of addresses 0, 31 and 63 each return 10'h155, with dout_valid one cycle after each.
- Masked write: write 10'h3FF to address 5 with wmask = 2'b11, then 10'h000 with wmask = 2'b01. A read of address 5 returns 10'h3E0.
- Collision: address 7 holds 10'h0AA. Write 10'h3FF with wmask = 2'b10 while reading address 7 in the same cycle. The read returns 10'h3EA with DPRAM_BYPASS_EN and 10'h0AA without it. A read of address 7 the next cycle returns 10'h3EA in both builds.
- RD_LAT = 2, back-to-back reads of addresses 1, 2, 3 holding 10'h001, 10'h002, 10'h003: dataout shows them on three consecutive cycles starting 2 cycles after the first read, with dout_valid high for exactly those 3 cycles.
- clear pulse in IDLE after writing 10'h123 to address 9: busy is high for 64 cycles. Writes and reads issued during the sweep have no effect and no dout_valid. Address 9 then reads back FILL.
- rst_n pulsed low at sweep address 20: busy stays high and the sweep restarts from address 0. busy falls 64 edges after release.

Source files
------------

// File: rtl/dpram_mask.sv
// -----------------------------------------------------------------------------
// dpram_mask
//
// Simple dual-port RAM (one write port, one read port, single clock) with
// per-lane write masking, a 1- or 2-cycle read pipeline and a hardware clear
// sequencer that fills every word with FILL after reset or on request.
//
// Optional build macro: DPRAM_BYPASS_EN
//   defined   : a same-cycle read and write to one address returns the written
//               lanes from datain and the unmasked lanes from memory.
//   undefined : the same collision returns the old memory word (read-first).
//
// Parameters
//   ADDR_W  address width, depth = 2**ADDR_W
//   DATA_W  word width, exact multiple of LANES
//   LANES   number of write-mask lanes, lane i = bits [i*LW +: LW]
//   RD_LAT  read latency in cycles (1 or 2)
//   FILL    value written to every word by the clear sweep
//
// Ports
//   clk         clock, all state changes on rising edge
//   rst_n       asynchronous active-low reset
//   write       write request (ignored while busy)
//   wmask       lane enables for the write
//   addr_w      write address
//   datain      write data
//   read        read request (ignored while busy)
//   addr_r      read address
//   clear       start a clear sweep (sampled only when idle)
//   dataout     read data, holds until the next completed read
//   dout_valid  one-cycle strobe marking new dataout
//   busy        clear sweep in progress
// -----------------------------------------------------------------------------
module dpram_mask #(
    parameter int                ADDR_W = 6,
    parameter int                DATA_W = 10,
    parameter int                LANES  = 2,
    parameter int                RD_LAT = 1,
    parameter logic [DATA_W-1:0] FILL   = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              write,
    input  logic [LANES-1:0]  wmask,
    input  logic [ADDR_W-1:0] addr_w,
    input  logic [DATA_W-1:0] datain,
    input  logic              read,
    input  logic [ADDR_W-1:0] addr_r,
    input  logic              clear,
    output logic [DATA_W-1:0] dataout,
    output logic              dout_valid,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int LW    = DATA_W / LANES;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] rd_word;

    logic              vld_p0;
    logic [DATA_W-1:0] rd_data_p0;
    logic              vld_last;
    logic [DATA_W-1:0] data_last;

    // Replace the lanes selected by mask in old_word with those of new_word.
    function automatic logic [DATA_W-1:0] merge_lanes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [LANES-1:0]  mask
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int i = 0; i < LANES; i++) begin
            if (mask[i]) begin
                res[i*LW +: LW] = new_word[i*LW +: LW];
            end
        end
        return res;
    endfunction

    // ---------------------------------------------------------------- control
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            CLEAR: begin
                // Pointer wraps back to 0 on the last word, ready for the next sweep.
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == {ADDR_W{1'b1}}) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (clear) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    assign busy  = (state_q == CLEAR);
    assign wr_en = (state_q == IDLE) && write;
    assign rd_en = (state_q == IDLE) && read;

    // ---------------------------------------------------------------- array
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem[ptr_q] <= FILL;
        end else if (wr_en) begin
            mem[addr_w] <= merge_lanes(mem[addr_w], datain, wmask);
        end
    end

`ifdef DPRAM_BYPASS_EN
    assign rd_word = (wr_en && (addr_w == addr_r))
                   ? merge_lanes(mem[addr_r], datain, wmask)
                   : mem[addr_r];
`else
    assign rd_word = mem[addr_r];
`endif

    // ---------------------------------------------------------------- stage p0: array fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= rd_en;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_p0 <= rd_word;
        end
    end

    // ---------------------------------------------------------------- stage p1: optional extra delay
    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              vld_p1;
            logic [DATA_W-1:0] rd_data_p1;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_p1 <= 1'b0;
                end else begin
                    vld_p1 <= vld_p0;
                end
            end

            always_ff @(posedge clk) begin
                if (vld_p0) begin
                    rd_data_p1 <= rd_data_p0;
                end
            end

            assign vld_last  = vld_p1;
            assign data_last = rd_data_p1;
        end else begin : g_lat1
            assign vld_last  = vld_p0;
            assign data_last = rd_data_p0;
        end
    endgenerate

    // ---------------------------------------------------------------- output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dataout    <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= vld_last;
            if (vld_last) begin
                dataout <= data_last;
            end
        end
    end

endmodule

// File: tb/tb_dpram_mask.sv
module tb_dpram_mask;

    localparam logic [9:0] FILL_V = 10'h155;

    typedef struct {
        logic [9:0] data;
        int         due;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       write;
    logic [1:0] wmask;
    logic [5:0] addr_w;
    logic [9:0] datain;
    logic       read;
    logic [5:0] addr_r;
    logic       clear;

    logic [9:0] dataout1, dataout2;
    logic       dout_valid1, dout_valid2;
    logic       busy1, busy2;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;

    dpram_mask #(.ADDR_W(6), .DATA_W(10), .LANES(2), .RD_LAT(1), .FILL(FILL_V)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .write(write), .wmask(wmask), .addr_w(addr_w),
        .datain(datain), .read(read), .addr_r(addr_r), .clear(clear),
        .dataout(dataout1), .dout_valid(dout_valid1), .busy(busy1)
    );

    dpram_mask #(.ADDR_W(6), .DATA_W(10), .LANES(2), .RD_LAT(2), .FILL(FILL_V)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .write(write), .wmask(wmask), .addr_w(addr_w),
        .datain(datain), .read(read), .addr_r(addr_r), .clear(clear),
        .dataout(dataout2), .dout_valid(dout_valid2), .busy(busy2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitors: every dout_valid must match the oldest pending read, in data and cycle.
    always @(negedge clk) begin
        if (dout_valid1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL lat1_unexpected_valid: dataout=%h at cycle %0d, no read pending", dataout1, cyc);
            end else begin
                e1 = q1.pop_front();
                if (dataout1 !== e1.data || cyc != e1.due) begin
                    errors++;
                    $display("FAIL lat1_read: got %h at cycle %0d, expected %h at cycle %0d",
                             dataout1, cyc, e1.data, e1.due);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (dout_valid2) begin
            checks++;
            if (q2.size() == 0) begin
                errors++;
                $display("FAIL lat2_unexpected_valid: dataout=%h at cycle %0d, no read pending", dataout2, cyc);
            end else begin
                e2 = q2.pop_front();
                if (dataout2 !== e2.data || cyc != e2.due) begin
                    errors++;
                    $display("FAIL lat2_read: got %h at cycle %0d, expected %h at cycle %0d",
                             dataout2, cyc, e2.data, e2.due);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // All tasks are entered at a falling edge and return at the next falling edge.
    task automatic op(input logic w, input logic [5:0] aw, input logic [9:0] d, input logic [1:0] m,
                      input logic r, input logic [5:0] ar, input logic [9:0] exp_rd);
        write  = w;
        addr_w = aw;
        datain = d;
        wmask  = m;
        read   = r;
        addr_r = ar;
        if (r) begin
            q1.push_back('{data: exp_rd, due: cyc + 1 + 1});
            q2.push_back('{data: exp_rd, due: cyc + 1 + 2});
        end
        @(negedge clk);
        write = 1'b0;
        read  = 1'b0;
        wmask = 2'b00;
    endtask

    task automatic wr(input logic [5:0] a, input logic [9:0] d, input logic [1:0] m);
        op(1'b1, a, d, m, 1'b0, 6'd0, 10'h000);
    endtask

    task automatic rd(input logic [5:0] a, input logic [9:0] exp_rd);
        op(1'b0, 6'd0, 10'h000, 2'b00, 1'b1, a, exp_rd);
    endtask

    // Counts falling edges until busy drops; optionally fires dropped requests meanwhile.
    task automatic busy_count(input string name, input bit junk);
        int n1, n2;
        n1 = 0;
        n2 = 0;
        if (junk) begin
            write = 1'b1; addr_w = 6'd9; datain = 10'h3FF; wmask = 2'b11;
            read = 1'b1; addr_r = 6'd9;
        end
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (n1 == 0 && !busy1) n1 = i;
            if (n2 == 0 && !busy2) n2 = i;
            if (n1 != 0 && n2 != 0) break;
            if (junk) begin
                write = 1'b1; addr_w = 6'(i); datain = 10'h3FF; wmask = 2'b11;
                read = 1'b1; addr_r = 6'd9;
            end
        end
        write = 1'b0;
        read  = 1'b0;
        wmask = 2'b00;
        chk({name, "_lat1"}, n1, 64);
        chk({name, "_lat2"}, n2, 64);
    endtask

    initial begin
        rst_n  = 1'b0;
        write  = 1'b0;
        wmask  = 2'b00;
        addr_w = '0;
        datain = '0;
        read   = 1'b0;
        addr_r = '0;
        clear  = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_dataout1", dataout1, 10'h000);
        chk("rst_valid1",   dout_valid1, 1'b0);
        chk("rst_busy1",    busy1, 1'b1);
        chk("rst_dataout2", dataout2, 10'h000);
        chk("rst_valid2",   dout_valid2, 1'b0);
        chk("rst_busy2",    busy2, 1'b1);

        rst_n = 1'b1;
        busy_count("init_sweep_busy", 1'b0);

        // First read lands on the first IDLE edge.
        rd(6'd0,  FILL_V);
        rd(6'd31, FILL_V);
        rd(6'd63, FILL_V);

        // Masked write: lane 0 cleared, lane 1 kept.
        wr(6'd5, 10'h3FF, 2'b11);
        wr(6'd5, 10'h000, 2'b01);
        rd(6'd5, 10'h3E0);

        // Collision on address 7 with only the upper lane written.
        wr(6'd7, 10'h0AA, 2'b11);
`ifdef DPRAM_BYPASS_EN
        op(1'b1, 6'd7, 10'h3FF, 2'b10, 1'b1, 6'd7, 10'h3EA);
`else
        op(1'b1, 6'd7, 10'h3FF, 2'b10, 1'b1, 6'd7, 10'h0AA);
`endif
        rd(6'd7, 10'h3EA);

        // Back-to-back reads.
        wr(6'd1, 10'h001, 2'b11);
        wr(6'd2, 10'h002, 2'b11);
        wr(6'd3, 10'h003, 2'b11);
        rd(6'd1, 10'h001);
        rd(6'd2, 10'h002);
        rd(6'd3, 10'h003);

        // Clear sweep with requests dropped while busy.
        wr(6'd9, 10'h123, 2'b11);
        repeat (3) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        busy_count("clear_sweep_busy", 1'b1);
        rd(6'd9, FILL_V);
        rd(6'd5, FILL_V);
        rd(6'd7, FILL_V);
        repeat (4) @(negedge clk);

        // Reset pulse in the middle of a sweep, just after address 20 is written.
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (20) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_dataout1", dataout1, 10'h000);
        chk("midrst_busy1",    busy1, 1'b1);
        chk("midrst_dataout2", dataout2, 10'h000);
        chk("midrst_busy2",    busy2, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        busy_count("restart_sweep_busy", 1'b0);
        rd(6'd20, FILL_V);
        rd(6'd0,  FILL_V);

        repeat (6) @(negedge clk);
        chk("lat1_pending_reads", q1.size(), 0);
        chk("lat2_pending_reads", q2.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
